// File: rtl/wb_regfile_scoreboard.sv
// Write-back consumer: 16x16 register file with R0 hardwired to zero, two combinational
// read ports, and a per-register busy scoreboard that stalls decode on RAW/WAW hazards.
// Optional same-cycle write-through bypass is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile_scoreboard #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rs1_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic              rs2_en,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;

  logic wb_wr;
  logic resolved1, resolved2;
  logic hazard1, hazard2, waw;
  logic issue_ok;

  assign wb_wr = wb_en && (wb_rd != '0);

`ifdef WB_REGFILE_BYPASS_EN
  assign resolved1 = wb_en && (wb_rd == rs1_addr);
  assign resolved2 = wb_en && (wb_rd == rs2_addr);
`else
  assign resolved1 = 1'b0;
  assign resolved2 = 1'b0;
`endif

  assign hazard1 = rs1_en && (rs1_addr != '0) && busy_q[rs1_addr] && !resolved1;
  assign hazard2 = rs2_en && (rs2_addr != '0) && busy_q[rs2_addr] && !resolved2;
  // A matching write-back retires the old producer this cycle, so the new one may issue.
  assign waw     = issue_en && (issue_rd != '0) && busy_q[issue_rd]
                   && !(wb_en && (wb_rd == issue_rd));
  assign stall   = hazard1 || hazard2 || waw;
  assign issue_ok = issue_en && !stall && (issue_rd != '0);

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_wr && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wb_wr && (wb_rd == rs2_addr)) rs2_data = wb_data;
`endif
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_wr) begin
      regs_d[wb_rd] = wb_data;
      busy_d[wb_rd] = 1'b0;
    end
    // Set after clear: a same-register issue and write-back leaves the new producer pending.
    if (issue_ok) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_d[i] = '0;
      end
      busy_d = '0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Self-checking bench for wb_regfile_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based reference model.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        rs1_en;
  logic [3:0]  rs1_addr;
  logic        rs2_en;
  logic [3:0]  rs2_addr;
  logic        issue_en;
  logic [3:0]  issue_rd;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        stall;
  logic [15:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .rs1_en   (rs1_en),
    .rs1_addr (rs1_addr),
    .rs2_en   (rs2_en),
    .rs2_addr (rs2_addr),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .stall    (stall),
    .busy_vec (busy_vec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays holding architectural state.
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  bit          model_valid = 0;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  function automatic bit src_waits(input bit en, input logic [3:0] a);
    bit written_now;
    written_now = wb_en && (wb_rd == a);
    return en && (a != 0) && m_busy[a] && !(Bypass && written_now);
  endfunction

  function automatic bit m_stall();
    bit waw;
    waw = issue_en && (issue_rd != 0) && m_busy[issue_rd] && !(wb_en && wb_rd == issue_rd);
    return src_waits(rs1_en, rs1_addr) || src_waits(rs2_en, rs2_addr) || waw;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 0) return 16'h0;
    if (Bypass && wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] <= 16'h0;
        m_busy[i] <= 1'b0;
      end
      model_valid <= 1'b1;
    end else begin
      bit st;
      st = m_stall();
      if (wb_en && wb_rd != 0) begin
        m_regs[wb_rd] <= wb_data;
        m_busy[wb_rd] <= 1'b0;
      end
      // Later nonblocking write wins, matching "set beats clear".
      if (issue_en && !st && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_rs1_data", {16'h0, rs1_data}, {16'h0, m_read(rs1_addr)});
      chk("model_rs2_data", {16'h0, rs2_data}, {16'h0, m_read(rs2_addr)});
      chk("model_stall", {31'h0, stall}, {31'h0, m_stall()});
      chk("model_busy_vec", {16'h0, busy_vec}, {16'h0, m_busy_vec()});
    end
  end

  task automatic idle();
    reset = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    rs1_en = 0; rs1_addr = 0; rs2_en = 0; rs2_addr = 0;
    issue_en = 0; issue_rd = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc();
    // Reset then read
    reset = 0; rs1_en = 1; rs1_addr = 5; rs2_en = 1; rs2_addr = 0;
    #3;
    chk("reset_rs1", {16'h0, rs1_data}, 32'h0);
    chk("reset_rs2", {16'h0, rs2_data}, 32'h0);
    chk("reset_busy", {16'h0, busy_vec}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);

    // Basic write, then R0 write dropped
    cyc(); idle(); wb_en = 1; wb_rd = 3; wb_data = 16'hBEEF;
    cyc(); idle(); wb_en = 1; wb_rd = 0; wb_data = 16'h1234; rs1_addr = 3; rs2_addr = 0;
    #3;
    chk("write_r3", {16'h0, rs1_data}, 32'hBEEF);
    cyc(); idle(); rs2_addr = 0;
    #3;
    chk("r0_still_zero", {16'h0, rs2_data}, 32'h0);

    // RAW stall on R7
    cyc(); idle(); issue_en = 1; issue_rd = 7;
    cyc(); idle(); rs1_en = 1; rs1_addr = 7;
    #3;
    chk("raw_busy7", {16'h0, busy_vec}, 32'h0080);
    chk("raw_stall", {31'h0, stall}, 32'h1);
    cyc(); wb_en = 1; wb_rd = 7; wb_data = 16'h00A5;
    #3;
    if (Bypass) begin
      chk("raw_wb_cycle_stall", {31'h0, stall}, 32'h0);
      chk("raw_wb_cycle_data", {16'h0, rs1_data}, 32'h00A5);
    end else begin
      chk("raw_wb_cycle_stall", {31'h0, stall}, 32'h1);
    end
    cyc(); wb_en = 0;
    #3;
    chk("raw_after_stall", {31'h0, stall}, 32'h0);
    chk("raw_after_data", {16'h0, rs1_data}, 32'h00A5);

    // WAW block on R4
    cyc(); idle(); issue_en = 1; issue_rd = 4;
    cyc();
    #3;
    chk("waw_stall", {31'h0, stall}, 32'h1);
    cyc();
    #3;
    chk("waw_busy_unchanged", {16'h0, busy_vec}, 32'h0010);
    wb_en = 1; wb_rd = 4; wb_data = 16'h4444;
    #1;
    chk("waw_wb_stall", {31'h0, stall}, 32'h0);
    cyc(); idle();
    #3;
    chk("waw_wb_busy", {16'h0, busy_vec}, 32'h0010);

    // Simultaneous issue R2 with write-back R9
    cyc(); issue_en = 1; issue_rd = 9;
    cyc(); issue_rd = 2; wb_en = 1; wb_rd = 9; wb_data = 16'h9999;
    #3;
    chk("simul_stall", {31'h0, stall}, 32'h0);
    cyc(); idle();
    #3;
    chk("simul_busy", {16'h0, busy_vec}, 32'h0014);

    // Reset mid-operation
    cyc(); issue_en = 1; issue_rd = 1;
    cyc(); issue_rd = 6; wb_en = 1; wb_rd = 6; wb_data = 16'h5555;
    cyc(); idle(); rs1_addr = 6;
    #3;
    chk("pre_reset_busy", {16'h0, busy_vec}, 32'h0056);
    chk("pre_reset_r6", {16'h0, rs1_data}, 32'h5555);
    reset = 1; wb_en = 1; wb_rd = 6; wb_data = 16'h7777;
    cyc(); idle(); rs1_addr = 6;
    #3;
    chk("mid_reset_busy", {16'h0, busy_vec}, 32'h0);
    chk("mid_reset_r6", {16'h0, rs1_data}, 32'h0);

    // Randomized traffic checked by the negedge compare process
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset    = ($urandom_range(0, 99) == 0);
      wb_en    = ($urandom_range(0, 2) != 0);
      wb_rd    = 4'($urandom_range(0, 15));
      wb_data  = 16'($urandom);
      rs1_en   = $urandom_range(0, 1) == 1;
      rs1_addr = 4'($urandom_range(0, 15));
      rs2_en   = $urandom_range(0, 1) == 1;
      rs2_addr = 4'($urandom_range(0, 15));
      issue_en = ($urandom_range(0, 2) != 0);
      issue_rd = 4'($urandom_range(0, 15));
    end
    cyc(); idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_regfile_scoreboard.md
Name: wb_regfile_scoreboard

Overview:
- Consumer end of the write-back interface: accepts the 16-bit result from the write-back stage and commits it to a 16-entry x 16-bit architectural register file.
- Serves two combinational read ports to the decode stage.
- Tracks in-flight destination registers with a per-register busy scoreboard.
- Raises a stall to decode when a source operand is still pending.

Parameters:
- DATA_W, 16, register and data width.
- NREGS, 16, number of architectural registers; R0 is hardwired to zero.
- ADDR_W, 4, register address width; must equal log2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_en  in  1  write-back valid; commit wb_data to wb_rd this cycle.
- wb_rd  in  ADDR_W  write-back destination register.
- wb_data  in  DATA_W  write-back result.
- rs1_en  in  1  decode uses source operand 1.
- rs1_addr  in  ADDR_W  source register 1 address.
- rs2_en  in  1  decode uses source operand 2.
- rs2_addr  in  ADDR_W  source register 2 address.
- issue_en  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- rs1_data  out  DATA_W  read data, port 1 (combinational).
- rs2_data  out  DATA_W  read data, port 2 (combinational).
- stall  out  1  decode must hold; issue is blocked this cycle.
- busy_vec  out  NREGS  scoreboard state, bit i set = register i pending.

Behaviour:
- Reset, synchronous, active-high: on a clk edge with reset=1, all registers clear to 0 and busy_vec clears to 0. wb_en and issue_en are ignored in that cycle. This applies equally mid-operation: every pending write is discarded.
- R0: reads always return 0. Writes to R0 are dropped. busy[0] is never set.
- Write: on the clk edge, if wb_en=1 and wb_rd!=0, then regs[wb_rd] <= wb_data. Write latency is 1 cycle.
- Read without bypass: rsN_data = regs[rsN_addr], using the pre-edge contents.
- Scoreboard on each clk edge:
  - If wb_en=1 and wb_rd!=0, clear busy[wb_rd].
  - If issue_en=1, stall=0 and issue_rd!=0, set busy[issue_rd].
  - When issue and write-back target the same register in the same cycle, the set wins: the new producer is pending.
- Stall, combinational: stall = hazard1 | hazard2 | waw.
  - hazardN = rsN_en & (rsN_addr!=0) & busy[rsN_addr] & ~resolvedN.
  - resolvedN = 0 without the optional feature.
  - waw = issue_en & (issue_rd!=0) & busy[issue_rd] & ~(wb_en & wb_rd==issue_rd). This prevents a second in-flight producer for the same register.
- issue_en while stall=1: ignored, so no busy bit is set. Decode retries the next cycle.
- Write-back to a register whose busy bit is clear: the data is still written and busy stays 0. This is not an error.
- Addresses are ADDR_W bits wide and always in range; no wrap handling is needed.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- When defined:
  - If wb_en=1, wb_rd!=0 and wb_rd==rsN_addr, then rsN_data = wb_data in the same cycle (write-through bypass).
  - resolvedN = wb_en & (wb_rd==rsN_addr), so a RAW hazard on a register being written back this cycle does not stall.
- When undefined:
  - Reads return stored contents only.
  - A read of a busy register stalls until the cycle after its write-back.

Test Plan:
- Reset then read: assert reset 1 cycle, read rs1=5 and rs2=0 -> both data = 0x0000, busy_vec = 0x0000, stall = 0.
- Basic write/read: wb_en, wb_rd=3, wb_data=0xBEEF, then read rs1_addr=3 next cycle -> rs1_data = 0xBEEF. wb_rd=0 with data 0x1234 -> R0 still reads 0.
- RAW stall:
  - Issue issue_rd=7 -> busy_vec[7]=1.
  - Next cycle rs1_en=1, rs1_addr=7 -> stall=1 until wb_en with wb_rd=7 and data 0x00A5.
  - Bypass defined: stall=0 and rs1_data=0x00A5 in the write-back cycle.
  - Bypass undefined: stall=1 in the write-back cycle, stall=0 and rs1_data=0x00A5 the cycle after.
- WAW block: busy[4]=1, issue_en with issue_rd=4 and no write-back -> stall=1, busy unchanged. Same request coinciding with wb_rd=4 -> stall=0, busy[4] remains 1.
- Simultaneous issue/write-back to different registers: issue_rd=2 with wb_rd=9 (busy[9]=1) -> after the edge busy[2]=1 and busy[9]=0.
- Reset mid-operation: busy[1,6]=1 and R6=0x5555, assert reset concurrent with wb_en, wb_rd=6, data 0x7777 -> busy_vec=0, R6 reads 0x0000.
